// File: rtl/sr_sequential_if.sv
// Request/response bundle for the multi-cycle right shifter.
// master = multicycle-op controller, slave = shifter.
`timescale 1ns/1ps
interface sr_sequential_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] amount;
  logic               arith;
  logic               ready;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, a, amount, arith,
    input  ready, done, result
  );

  modport slave (
    input  start, a, amount, arith,
    output ready, done, result
  );
endinterface

// File: rtl/sr_sequential.sv
// 32-bit logical/arithmetic right shifter, one amount bit per cycle (16,8,4,2,1): start-to-done 5 cycles.
// ready is low only while shifting; a start in the done cycle chains the next op back-to-back.
`timescale 1ns/1ps
module sr_sequential (
  input  logic           clock,
  input  logic           reset_n,
  sr_sequential_if.slave bus
);
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   w_q, w_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         k_q, k_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  logic               arith_q, arith_d;
  logic               sign_q, sign_d;

  logic               accept;
  logic               fill;
  logic [SHAMT_W-1:0] step;
  logic [WIDTH-1:0]   stage_w;

  assign accept = bus.start && (state_q != S_SHIFT);

  // Fill comes from the sign captured at acceptance, not from the working register.
  assign fill    = arith_q & sign_q;
  assign step    = SHAMT_W'(1) << k_q;
  assign stage_w = (w_q >> step) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> step));

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    result_d = result_q;
    k_d      = k_q;
    amt_d    = amt_q;
    arith_d  = arith_q;
    sign_d   = sign_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          w_d     = bus.a;
          sign_d  = bus.a[WIDTH-1];
          amt_d   = bus.amount;
          arith_d = bus.arith;
          k_d     = 3'd4;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (amt_q[k_q]) begin
          w_d = stage_w;
        end
        if (k_q == 3'd0) begin
          result_d = w_d;
          state_d  = S_DONE;
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      w_q      <= '0;
      result_q <= '0;
      k_q      <= '0;
      amt_q    <= '0;
      arith_q  <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      result_q <= result_d;
      k_q      <= k_d;
      amt_q    <= amt_d;
      arith_q  <= arith_d;
      sign_q   <= sign_d;
    end
  end

  assign bus.ready  = (state_q != S_SHIFT);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_sr_sequential.sv
// Directed and randomized checks of sr_sequential against a plain >>/>>> reference.
`timescale 1ns/1ps
module tb_sr_sequential;
  logic        clock = 1'b0;
  logic        reset_n;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_res;

  sr_sequential_if bus ();

  sr_sequential dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int amt, input logic ar);
    logic signed [31:0] s;
    s = a;
    if (ar) return 32'(s >>> amt);
    return a >> amt;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  // Issue one op from IDLE or DONE and follow it to completion.
  // disturb < 0: random ignored starts during the shift; disturb > 0: one start pulse at that cycle.
  task automatic do_op(input logic [31:0] a, input logic [4:0] amt, input logic ar, input int disturb);
    logic [31:0] expv;
    expv       = ref_shift(a, int'(amt), ar);
    bus.start  = 1'b1;
    bus.a      = a;
    bus.amount = amt;
    bus.arith  = ar;
    @(posedge clock); #1;
    check("accept_ready", {31'b0, bus.ready}, 32'd0);
    check("accept_done", {31'b0, bus.done}, 32'd0);
    for (int j = 1; j <= 5; j++) begin
      if (disturb < 0 && j < 5) begin
        bus.start  = 1'($urandom);
        bus.a      = $urandom;
        bus.amount = 5'($urandom);
        bus.arith  = 1'($urandom);
      end else if (j == disturb) begin
        bus.start  = 1'b1;
        bus.a      = 32'h0;
        bus.amount = 5'd1;
        bus.arith  = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clock); #1;
      if (j < 5) begin
        check("busy_ready", {31'b0, bus.ready}, 32'd0);
        check("busy_done", {31'b0, bus.done}, 32'd0);
        check("busy_result_held", bus.result, exp_res);
      end else begin
        check("done_pulse", {31'b0, bus.done}, 32'd1);
        check("done_ready", {31'b0, bus.ready}, 32'd1);
        check("result", bus.result, expv);
      end
    end
    bus.start = 1'b0;
    exp_res   = expv;
  endtask

  task automatic idle_cycle();
    @(posedge clock); #1;
    check("idle_done", {31'b0, bus.done}, 32'd0);
    check("idle_ready", {31'b0, bus.ready}, 32'd1);
    check("idle_result_held", bus.result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held together with start: reset must win.
    reset_n    = 1'b0;
    bus.start  = 1'b1;
    bus.a      = 32'hFFFF_FFFF;
    bus.amount = 5'd5;
    bus.arith  = 1'b1;
    exp_res    = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_ready", {31'b0, bus.ready}, 32'd1);
    check("reset_done", {31'b0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'h0);
    @(negedge clock);
    bus.start = 1'b0;
    reset_n   = 1'b1;
    idle_cycle();

    do_op(32'h8000_0000, 5'd31, 1'b0, 0);
    idle_cycle();
    do_op(32'h8000_0000, 5'd31, 1'b1, 0);
    idle_cycle();
    do_op(32'hF0F0_F0F0, 5'd4, 1'b1, 0);
    do_op(32'hF0F0_F0F0, 5'd4, 1'b0, 0);
    idle_cycle();
    do_op(32'h1234_5678, 5'd0, 1'b0, 0);
    idle_cycle();

    // Start pulsed mid-shift is ignored; idle_cycle confirms a single done pulse.
    do_op(32'hFFFF_0000, 5'd16, 1'b0, 2);
    idle_cycle();

    // Start held in the DONE cycle chains a second op, completing 5 cycles later.
    do_op(32'h1357_9BDF, 5'd3, 1'b1, 0);
    do_op(32'h0000_0100, 5'd8, 1'b0, 0);
    idle_cycle();

    for (int ar = 0; ar < 2; ar++) begin
      for (int amt = 0; amt < 32; amt++) begin
        do_op($urandom | (32'(amt[0]) << 31), 5'(amt), 1'(ar), -1);
        if (amt % 3 == 0) idle_cycle();
      end
    end
    idle_cycle();

    // Reset right after E3 aborts the op with no done pulse.
    bus.start  = 1'b1;
    bus.a      = 32'hDEAD_BEEF;
    bus.amount = 5'd7;
    bus.arith  = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    exp_res = 32'h0;
    check("abort_ready", {31'b0, bus.ready}, 32'd1);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_result", bus.result, 32'h0);
    @(posedge clock); #1;
    check("abort_no_done", {31'b0, bus.done}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle_cycle();
    do_op(32'hC000_0003, 5'd1, 1'b1, 0);
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
